// File: rtl/and_or_arbiter.sv
// Round-robin arbiter that shares one external combinational and_or unit
// between two requesters and returns tagged results on one response channel.
module and_or_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         reqValid,
  output logic [1:0]         reqReady,
  input  logic [2*WIDTH-1:0] reqAIn,
  input  logic [2*WIDTH-1:0] reqBIn,
  input  logic [1:0]         reqDoAnd,
  input  logic [1:0]         reqDoOr,
  output logic [WIDTH-1:0]   aluAIn,
  output logic [WIDTH-1:0]   aluBIn,
  output logic               aluDoAnd,
  output logic               aluDoOr,
  input  logic [WIDTH-1:0]   aluOut,
  input  logic               aluIsAnd,
  output logic               respValid,
  input  logic               respReady,
  output logic [WIDTH-1:0]   respOut,
  output logic               respIsAnd,
  output logic               respErr,
  output logic               respId
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   errFlag;
  logic   idReg;

  logic             grantValid;
  logic             grantId;
  logic [WIDTH-1:0] grantA;
  logic [WIDTH-1:0] grantB;
  logic             grantAnd;
  logic             grantOr;
  logic             grantIllegal;

  // Handshakes: a request transfers on an edge where reqValid[i] && reqReady[i];
  // a response transfers on an edge where respValid && respReady. Valid may not
  // depend on ready; a request must hold its inputs stable until it transfers.
  always_comb begin
    grantId      = reqValid[prio] ? prio : ~prio;
    grantValid   = (state == IDLE) && (reqValid != 2'b00) && !rst;
    grantA       = grantId ? reqAIn[2*WIDTH-1:WIDTH] : reqAIn[WIDTH-1:0];
    grantB       = grantId ? reqBIn[2*WIDTH-1:WIDTH] : reqBIn[WIDTH-1:0];
    grantAnd     = reqDoAnd[grantId];
    grantOr      = reqDoOr[grantId];
    grantIllegal = (grantAnd == grantOr);
    reqReady     = 2'b00;
    if (grantValid) begin
      reqReady[grantId] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      errFlag   <= 1'b0;
      idReg     <= 1'b0;
      aluAIn    <= '0;
      aluBIn    <= '0;
      aluDoAnd  <= 1'b0;
      aluDoOr   <= 1'b0;
      respValid <= 1'b0;
      respOut   <= '0;
      respIsAnd <= 1'b0;
      respErr   <= 1'b0;
      respId    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            aluAIn   <= grantA;
            aluBIn   <= grantB;
            // Illegal ops still occupy a slot but never drive both selects.
            aluDoAnd <= grantAnd && !grantIllegal;
            aluDoOr  <= grantOr && !grantIllegal;
            errFlag  <= grantIllegal;
            idReg    <= grantId;
            state    <= EXEC;
          end
        end
        EXEC: begin
          respOut   <= errFlag ? '0 : aluOut;
          respIsAnd <= errFlag ? 1'b0 : aluIsAnd;
          respErr   <= errFlag;
          respId    <= idReg;
          respValid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (respReady) begin
            respValid <= 1'b0;
            prio      <= ~respId;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_or_arbiter.sv
// Directed bench for and_or_arbiter: vector table for single requests plus
// hand-written contention, fairness, backpressure and reset sequences.
module tb_and_or_arbiter;
  localparam int WIDTH = 4;
  localparam int EXP_W = WIDTH + 3;

  logic               clk;
  logic               rst;
  logic [1:0]         reqValid;
  logic [1:0]         reqReady;
  logic [2*WIDTH-1:0] reqAIn;
  logic [2*WIDTH-1:0] reqBIn;
  logic [1:0]         reqDoAnd;
  logic [1:0]         reqDoOr;
  logic [WIDTH-1:0]   aluAIn;
  logic [WIDTH-1:0]   aluBIn;
  logic               aluDoAnd;
  logic               aluDoOr;
  logic [WIDTH-1:0]   aluOut;
  logic               aluIsAnd;
  logic               respValid;
  logic               respReady;
  logic [WIDTH-1:0]   respOut;
  logic               respIsAnd;
  logic               respErr;
  logic               respId;

  and_or_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqAIn(reqAIn), .reqBIn(reqBIn),
    .reqDoAnd(reqDoAnd), .reqDoOr(reqDoOr),
    .aluAIn(aluAIn), .aluBIn(aluBIn),
    .aluDoAnd(aluDoAnd), .aluDoOr(aluDoOr),
    .aluOut(aluOut), .aluIsAnd(aluIsAnd),
    .respValid(respValid), .respReady(respReady),
    .respOut(respOut), .respIsAnd(respIsAnd),
    .respErr(respErr), .respId(respId)
  );

  // Stand-in for the external and_or unit.
  assign aluOut   = aluDoAnd ? (aluAIn & aluBIn) : (aluDoOr ? (aluAIn | aluBIn) : '0);
  assign aluIsAnd = aluDoAnd;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];   // {id, err, isAnd, out}
  int   resp_cyc_q[$];
  logic resp_id_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && respValid && respReady) begin
      resp_cyc_q.push_back(cyc);
      resp_id_q.push_back(respId);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got id=%0d out=0x%0h, expected no response", respId, respOut);
      end else begin
        check("resp_fields", {respId, respErr, respIsAnd, respOut}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic da, input logic dor);
    reqValid[id] = 1'b1;
    reqAIn[int'(id)*WIDTH +: WIDTH] = a;
    reqBIn[int'(id)*WIDTH +: WIDTH] = b;
    reqDoAnd[id] = da;
    reqDoOr[id]  = dor;
  endtask

  // Clocks until n requests are accepted, optionally dropping each on accept.
  task automatic serve(input int n, input bit drop);
    int got;
    logic [1:0] r;
    got = 0;
    for (int k = 0; k < 40 && got < n; k++) begin
      #1;
      r = reqReady;
      step();
      if (r[0]) begin got++; if (drop) reqValid[0] = 1'b0; end
      if (r[1]) begin got++; if (drop) reqValid[1] = 1'b0; end
    end
    check("serve_count", got, n);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (exp_q.size() != 0 || respValid); k++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             da;
    logic             dor;
    logic [WIDTH-1:0] expOut;
    logic             expIsAnd;
    logic             expErr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'b1100, 4'b1010, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'b1010, 4'b0101, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 4'b0110, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};

    rst = 1'b1;
    reqValid = '0; reqAIn = '0; reqBIn = '0; reqDoAnd = '0; reqDoOr = '0;
    respReady = 1'b0;
    step(); step();
    check("rst_respValid", respValid, 0);
    check("rst_reqReady", reqReady, 0);
    check("rst_resp", {respOut, respIsAnd, respErr, respId}, 0);
    check("rst_alu", {aluAIn, aluBIn, aluDoAnd, aluDoOr}, 0);
    rst = 1'b0;
    step();

    // Single requests, one at a time, respReady held high.
    respReady = 1'b1;
    foreach (vecs[i]) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].da, vecs[i].dor);
      #1;
      check("tbl_reqReady", reqReady, vecs[i].id ? 2'b10 : 2'b01);
      exp_q.push_back({vecs[i].id, vecs[i].expErr, vecs[i].expIsAnd, vecs[i].expOut});
      step();
      reqValid = 2'b00;
      check("tbl_exec_respValid", respValid, 0);
      check("tbl_exec_reqReady", reqReady, 0);
      check("tbl_exec_aluA", aluAIn, vecs[i].a);
      check("tbl_exec_aluDo", {aluDoAnd, aluDoOr},
            {vecs[i].da & ~vecs[i].dor, vecs[i].dor & ~vecs[i].da});
      step();
      check("tbl_latency_respValid", respValid, 1);
      step();
      check("tbl_idle_respValid", respValid, 0);
    end

    // Contention: both valid at once, prio is 0 so req0 goes first.
    set_req(1'b0, 4'b0011, 4'b0100, 1'b0, 1'b1);
    set_req(1'b1, 4'b1111, 4'b0101, 1'b1, 1'b0);
    #1;
    check("cont_first_grant", reqReady, 2'b01);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0111});
    exp_q.push_back({1'b1, 1'b0, 1'b1, 4'b0101});
    serve(2, 1'b1);
    drain();

    // Fairness: both held valid across 4 grants.
    resp_cyc_q.delete();
    resp_id_q.delete();
    set_req(1'b0, 4'b1100, 4'b0110, 1'b1, 1'b0);
    set_req(1'b1, 4'b1000, 4'b0001, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b1, 4'b0100});
      exp_q.push_back({1'b1, 1'b0, 1'b0, 4'b1001});
    end
    serve(4, 1'b0);
    reqValid = 2'b00;
    drain();
    check("fair_count", resp_id_q.size(), 4);
    for (int k = 0; k < resp_id_q.size(); k++) begin
      check("fair_id", resp_id_q[k], k % 2);
      if (k > 0) check("fair_spacing", resp_cyc_q[k] - resp_cyc_q[k-1], 3);
    end

    // Backpressure: response held for 5 cycles while req1 waits.
    respReady = 1'b0;
    set_req(1'b0, 4'b1001, 4'b0011, 1'b1, 1'b0);
    #1;
    check("bp_grant", reqReady, 2'b01);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 4'b0001});
    step();
    reqValid[0] = 1'b0;
    set_req(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_respValid", respValid, 1);
      check("bp_resp", {respId, respErr, respIsAnd, respOut}, {1'b0, 1'b0, 1'b1, 4'b0001});
      check("bp_reqReady", reqReady, 0);
      step();
    end
    respReady = 1'b1;
    reqValid = 2'b00;
    step();
    check("bp_after_respValid", respValid, 0);
    check("bp_drained", exp_q.size(), 0);

    // Reset during EXEC: prio was 1, request dropped, prio back to 0.
    set_req(1'b1, 4'b0110, 4'b0110, 1'b1, 1'b0);
    #1;
    check("rst_mid_grant", reqReady, 2'b10);
    step();
    reqValid = 2'b00;
    rst = 1'b1;
    #1;
    check("rst_mid_respValid", respValid, 0);
    check("rst_mid_alu", {aluAIn, aluBIn, aluDoAnd, aluDoOr}, 0);
    check("rst_mid_resp", {respOut, respIsAnd, respErr, respId}, 0);
    step(); step();
    rst = 1'b0;
    step(); step();
    check("rst_mid_no_resp", respValid, 0);
    set_req(1'b0, 4'b0101, 4'b0011, 1'b1, 1'b0);
    set_req(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1);
    #1;
    check("rst_prio_grant", reqReady, 2'b01);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 4'b0001});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 4'b1111});
    serve(2, 1'b1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
